// File: rtl/soc_boot_copy.sv
// ---------------------------------------------------------------------------
// soc_boot_copy
//   Post-reset boot sequencer. Acts as a Wishbone classic master that copies
//   WORDS 32-bit words from a boot ROM bank into main RAM, then releases the
//   CPU from reset. A bus error or an access timeout parks the block in an
//   error state, and the CPU stays in reset.
//
//   Optional feature macro: SOC_BOOT_COPY_VERIFY_EN
//     When defined, every written word is read back (VRD) and compared with
//     the value that was written. A mismatch is treated as a copy failure.
//
// Ports
//   mem_clk_i    system clock, rising edge
//   mem_rst_i    asynchronous active-low reset
//   boot_select  source bank, latched in INIT
//   wb_*         Wishbone classic master port
//   cpu_rst_o    active-high CPU reset, dropped only after a successful copy
//   done_o       copy complete (sticky until reset)
//   err_o        copy failed (sticky until reset)
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | latch bank, clear word index
// RD    | read source word idx from the selected boot bank
// WR    | write the buffered word to destination word idx
// VRD   | read destination word idx back and compare (verify builds only)
// DONE  | copy finished, CPU released
// ERR   | bus error, timeout or verify mismatch, CPU held in reset
// ---------------------------------------------------------------------------
module soc_boot_copy #(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h1000_0000,
  parameter int          WORDS    = 256,
  parameter int          TIMEOUT  = 255
) (
  input  logic        mem_clk_i,
  input  logic        mem_rst_i,
  input  logic [1:0]  boot_select,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef SOC_BOOT_COPY_VERIFY_EN
  typedef enum logic [2:0] {
    ST_INIT = 3'd0, ST_RD = 3'd1, ST_WR = 3'd2,
    ST_DONE = 3'd3, ST_ERR = 3'd4, ST_VRD = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_INIT = 3'd0, ST_RD = 3'd1, ST_WR = 3'd2,
    ST_DONE = 3'd3, ST_ERR = 3'd4
  } state_e;
`endif

  localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);
  // The wait counter holds the number of stalled cycles already seen, so
  // the stall that brings it to TIMEOUT is the one that sees TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  bank_q, bank_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic [15:0] wait_q, wait_d;
  logic        gap_q, gap_d;

  logic        access;
  logic        stb_act;
  logic [31:0] idx_ofs;
  logic [31:0] src_adr;
  logic [31:0] dst_adr;

  assign idx_ofs = {14'd0, idx_q, 2'b00};
  assign src_adr = SRC_BASE | {4'd0, bank_q, 26'd0} | idx_ofs;
  assign dst_adr = DST_BASE + idx_ofs;

`ifdef SOC_BOOT_COPY_VERIFY_EN
  assign access = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_VRD);
`else
  assign access = (state_q == ST_RD) || (state_q == ST_WR);
`endif
  // gap_q marks the single idle-strobe cycle that follows a retry
  assign stb_act = access && !gap_q;

  always_ff @(posedge mem_clk_i or negedge mem_rst_i) begin
    if (!mem_rst_i) begin
      state_q <= ST_INIT;
      bank_q  <= 2'd0;
      idx_q   <= 16'd0;
      buf_q   <= 32'd0;
      wait_q  <= 16'd0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    wait_d  = wait_q;
    gap_d   = 1'b0;

    if (state_q == ST_INIT) begin
      bank_d  = boot_select;
      idx_d   = 16'd0;
      wait_d  = 16'd0;
      state_d = ST_RD;
    end else if (stb_act) begin
      if (wb_err_i) begin
        state_d = ST_ERR;
      end else if (wb_ack_i) begin
        wait_d = 16'd0;
        case (state_q)
          ST_RD: begin
            buf_d   = wb_dat_i;
            state_d = ST_WR;
          end
`ifdef SOC_BOOT_COPY_VERIFY_EN
          ST_WR: state_d = ST_VRD;
          ST_VRD: begin
            if (wb_dat_i != buf_q) begin
              state_d = ST_ERR;
            end else if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 16'd1;
              state_d = ST_RD;
            end
          end
`else
          ST_WR: begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 16'd1;
              state_d = ST_RD;
            end
          end
`endif
          default: state_d = state_q;
        endcase
      end else if (wb_rty_i) begin
        // drop stb for one cycle; the reissue starts a fresh timeout window
        gap_d  = 1'b1;
        wait_d = 16'd0;
      end else if (wait_q == TMO_LAST) begin
        state_d = ST_ERR;
      end else begin
        wait_d = wait_q + 16'd1;
      end
    end
  end

  always_comb begin
    wb_cyc_o = access;
    wb_stb_o = stb_act;
    wb_we_o  = (state_q == ST_WR);
    wb_sel_o = stb_act ? 4'hF : 4'h0;
    wb_dat_o = (state_q == ST_WR) ? buf_q : 32'd0;
    case (state_q)
      ST_RD:   wb_adr_o = src_adr;
      ST_WR:   wb_adr_o = dst_adr;
`ifdef SOC_BOOT_COPY_VERIFY_EN
      ST_VRD:  wb_adr_o = dst_adr;
`endif
      default: wb_adr_o = 32'd0;
    endcase
    cpu_rst_o = (state_q != ST_DONE);
    done_o    = (state_q == ST_DONE);
    err_o     = (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_soc_boot_copy.sv
module tb_soc_boot_copy;

  localparam int W = 4;
`ifdef SOC_BOOT_COPY_VERIFY_EN
  localparam int PER = 3;
`else
  localparam int PER = 2;
`endif
  // edge 1 is the INIT edge, then PER accesses per word
  localparam int EXP_EDGES = PER * W + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  boot_select = 2'd0;
  logic [31:0] wb_adr, wb_dat_o, s_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        s_ack, s_err, s_rty;
  logic        cpu_rst, done, err;

  // slave behaviour knobs, driven only from the main initial block
  logic        no_ack = 1'b0;
  logic        rty_en = 1'b0;
  logic        err_wr_en = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [1:0]  bank_exp = 2'd0;

  // slave state, written only by the monitor process
  logic [31:0] ram [8];
  int          cyc_cnt, rd_cnt, wr_cnt, rty_cyc, bad_bank;
  logic        rty_done;
  logic        tr_cyc [64];
  logic        tr_stb [64];
  logic        tr_we  [64];
  logic [31:0] tr_adr [64];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  soc_boot_copy #(
    .SRC_BASE(32'h0000_0000), .DST_BASE(32'h1000_0000), .WORDS(W), .TIMEOUT(255)
  ) dut (
    .mem_clk_i(clk), .mem_rst_i(rst_n), .boot_select(boot_select),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(s_dat), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty),
    .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err)
  );

  function automatic logic [31:0] rom_val(input logic [1:0] b, input logic [2:0] w);
    return 32'(b) * 32'd100 + (32'(w) + 32'd1) * 32'd11;
  endfunction

  // combinational-ack slave: ROM banks below 0x1000_0000, RAM above
  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    if (wb_adr[31:28] == 4'h1)
      s_dat = ram[wb_adr[4:2]] ^ ((corrupt_en && wb_adr[4:2] == 3'd2) ? 32'd1 : 32'd0);
    else
      s_dat = rom_val(wb_adr[27:26], wb_adr[4:2]);
    if (wb_cyc && wb_stb && !no_ack) begin
      if (rty_en && !rty_done && !wb_we && wb_adr[31:28] == 4'h0 && rd_cnt == 1) begin
        s_rty = 1'b1;
      end else begin
        s_ack = 1'b1;
        if (err_wr_en && wb_we) s_err = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt  <= 0;
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      rty_cyc  <= -1;
      bad_bank <= 0;
      rty_done <= 1'b0;
      for (int i = 0; i < 8; i++) ram[i] <= 32'hDEAD_0000 + 32'(i);
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      if (cyc_cnt < 64) begin
        tr_cyc[cyc_cnt] <= wb_cyc;
        tr_stb[cyc_cnt] <= wb_stb;
        tr_we[cyc_cnt]  <= wb_we;
        tr_adr[cyc_cnt] <= wb_adr;
      end
      if (wb_cyc && wb_stb) begin
        if (s_rty) begin
          rty_done <= 1'b1;
          rty_cyc  <= cyc_cnt;
        end
        if (s_ack && !s_err && wb_we) begin
          ram[wb_adr[4:2]] <= wb_dat_o;
          wr_cnt <= wr_cnt + 1;
        end
        if (s_ack && !wb_we && wb_adr[31:28] == 4'h0) begin
          rd_cnt <= rd_cnt + 1;
          if (wb_adr[27:26] != bank_exp) bad_bank <= bad_bank + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_copy(input int chg_at, input logic [1:0] chg_val, output int edges);
    edges = 0;
    while (!(done || err) && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == chg_at) boot_select = chg_val;
    end
  endtask

  typedef struct {
    logic [1:0]  sel_rst;
    logic [1:0]  sel_mid;
    logic [31:0] exp [4];
  } vec_t;

  vec_t vecs [4];
  int   edges;

  initial begin
    vecs[0] = '{sel_rst: 2'd0, sel_mid: 2'd0, exp: '{32'd11,  32'd22,  32'd33,  32'd44}};
    vecs[1] = '{sel_rst: 2'd1, sel_mid: 2'd3, exp: '{32'd111, 32'd122, 32'd133, 32'd144}};
    vecs[2] = '{sel_rst: 2'd2, sel_mid: 2'd1, exp: '{32'd211, 32'd222, 32'd233, 32'd244}};
    vecs[3] = '{sel_rst: 2'd3, sel_mid: 2'd0, exp: '{32'd311, 32'd322, 32'd333, 32'd344}};

    // reset values
    #12;
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // full copies from each bank, boot_select changed mid-copy
    for (int v = 0; v < 4; v++) begin
      boot_select = vecs[v].sel_rst;
      bank_exp    = vecs[v].sel_rst;
      do_reset();
      run_copy(3, vecs[v].sel_mid, edges);
      check($sformatf("v%0d_edges", v), 32'(edges), 32'(EXP_EDGES));
      check($sformatf("v%0d_done", v), 32'(done), 32'd1);
      check($sformatf("v%0d_err", v), 32'(err), 32'd0);
      check($sformatf("v%0d_cpu_rst", v), 32'(cpu_rst), 32'd0);
      check($sformatf("v%0d_cyc", v), 32'(wb_cyc), 32'd0);
      check($sformatf("v%0d_bad_bank", v), 32'(bad_bank), 32'd0);
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_ram%0d", v, i), ram[i], vecs[v].exp[i]);
    end

    // retry on the second source read
    boot_select = 2'd0;
    bank_exp    = 2'd0;
    rty_en      = 1'b1;
    do_reset();
    run_copy(0, 2'd0, edges);
    rty_en = 1'b0;
    check("rty_cycle", 32'(rty_cyc), 32'd3);
    check("rty_adr", tr_adr[3], 32'h0000_0004);
    check("rty_gap_cyc", 32'(tr_cyc[4]), 32'd1);
    check("rty_gap_stb", 32'(tr_stb[4]), 32'd0);
    check("rty_reissue_stb", 32'(tr_stb[5]), 32'd1);
    check("rty_reissue_we", 32'(tr_we[5]), 32'd0);
    check("rty_reissue_adr", tr_adr[5], 32'h0000_0004);
    check("rty_edges", 32'(edges), 32'(EXP_EDGES + 2));
    check("rty_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("rty_ram%0d", i), ram[i], vecs[0].exp[i]);

    // slave never responds
    no_ack = 1'b1;
    do_reset();
    @(posedge clk);
    #1;
    repeat (254) @(posedge clk);
    #1;
    check("tmo_early_err", 32'(err), 32'd0);
    check("tmo_early_cyc", 32'(wb_cyc), 32'd1);
    check("tmo_early_stb", 32'(wb_stb), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_cyc", 32'(wb_cyc), 32'd0);
    check("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
    check("tmo_done", 32'(done), 32'd0);
    no_ack = 1'b0;

    // err together with ack on the first write
    err_wr_en = 1'b1;
    do_reset();
    run_copy(0, 2'd0, edges);
    err_wr_en = 1'b0;
    check("errack_edges", 32'(edges), 32'd3);
    check("errack_err", 32'(err), 32'd1);
    check("errack_done", 32'(done), 32'd0);
    check("errack_cpu_rst", 32'(cpu_rst), 32'd1);
    check("errack_cyc", 32'(wb_cyc), 32'd0);

`ifdef SOC_BOOT_COPY_VERIFY_EN
    // destination word 2 reads back wrong
    corrupt_en = 1'b1;
    do_reset();
    run_copy(0, 2'd0, edges);
    corrupt_en = 1'b0;
    check("vfy_edges", 32'(edges), 32'd10);
    check("vfy_err", 32'(err), 32'd1);
    check("vfy_done", 32'(done), 32'd0);
    check("vfy_writes", 32'(wr_cnt), 32'd3);
    check("vfy_ram3", ram[3], 32'hDEAD_0003);
`endif

    // reset pulse mid-copy: abort, then restart from word 0 of the new bank
    boot_select = 2'd3;
    bank_exp    = 2'd3;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("abort_pre_cyc", 32'(wb_cyc), 32'd1);
    rst_n       = 1'b0;
    boot_select = 2'd0;
    bank_exp    = 2'd0;
    #1;
    check("abort_cyc", 32'(wb_cyc), 32'd0);
    check("abort_stb", 32'(wb_stb), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_adr", wb_adr, 32'h0000_0000);
    check("restart_cyc", 32'(wb_cyc), 32'd1);
    check("restart_we", 32'(wb_we), 32'd0);
    run_copy(0, 2'd0, edges);
    check("restart_edges", 32'(edges), 32'(EXP_EDGES - 1));
    check("restart_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("restart_ram%0d", i), ram[i], vecs[0].exp[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
